out_buffer: RTL and testbench
=============================

Name: out_buffer

Overview:
- Decoupling buffer between the control unit (CU) and the terminal output unit.
- Accepts display words from the CU over a 4-phase req/ack handshake and stores them in a small FIFO.
- Acks the CU immediately when space exists, so the CU does not wait for the slow display path.
- Drains the FIFO into the output unit over a second 4-phase req/ack handshake, one word per transaction, in order.

Parameters:
- DW, 16, data word width (matches output unit).
- DEPTH, 4, FIFO entries; power of 2, ≥2.
- AW, $clog2(DEPTH), pointer width (derived, not overridden).

Ports:
- clk  input  1  clock.
- rst_b  input  1  reset; asynchronous, active-low.
- cu_req  input  1  CU write request (level, 4-phase).
- cu_data  input  DW  word to display; valid while cu_req=1.
- cu_ack  output  1  acknowledge to CU.
- ou_req  output  1  request to output unit.
- ou_data  output  DW  word presented to output unit.
- ou_ack  input  1  acknowledge from output unit.
- count  output  AW+1  current FIFO occupancy, 0..DEPTH.
- full  output  1  count==DEPTH.
- empty  output  1  count==0.

Behaviour:
- Reset (async, rst_b=0):
  - cu_ack=0, ou_req=0, ou_data=0, count=0, empty=1, full=0.
  - Pointers=0; both FSMs to idle.
  - Reset mid-transaction discards all stored words; no handshake completes.
- Upstream FSM states U_IDLE, U_ACK:
  - U_IDLE: if cu_req=1 and !full, write cu_data at wr_ptr, wr_ptr++, cu_ack<=1, go to U_ACK.
  - U_IDLE, cu_req=1 and full: stall, cu_ack stays 0. No drop, no overwrite.
  - U_ACK: hold cu_ack=1 until cu_req=0 is sampled, then cu_ack<=0 and go to U_IDLE.
  - Each CU request is written exactly once, regardless of how long cu_req stays high.
  - Latency: cu_ack rises 1 cycle after cu_req is first sampled high with space available.
- Downstream FSM states D_IDLE, D_REQ, D_WAIT:
  - D_IDLE: if !empty, ou_data<=mem[rd_ptr], ou_req<=1, go to D_REQ.
  - D_REQ: hold ou_req and ou_data stable; on ou_ack=1, ou_req<=0, rd_ptr++ (pop), go to D_WAIT.
  - D_WAIT: on ou_ack=0 go to D_IDLE. The next word can be offered the cycle after.
  - ou_data keeps its last value when idle.
  - The word is popped only on ack, so the FIFO slot stays occupied until the output unit has displayed it.
- Occupancy:
  - Push and pop in the same cycle leave count unchanged.
  - Push-only increments count; pop-only decrements it.
  - Pointers wrap modulo DEPTH (natural AW-bit overflow).
  - full and empty are derived combinationally from count.
- Ordering: strict FIFO. A word written while the FIFO is empty reaches ou_req no earlier than 1 cycle after the write (registered read).
- Output unit asserts ack late (≈3 cycles after req); the buffer must tolerate any ack delay, including indefinite.

Optional Feature:
- Macro OUT_BUF_HWM_EN.
- Defined: extra output port hwm [AW:0], the high-water mark.
  - Reset 0.
  - Updated each cycle to max(hwm, next count).
  - Never decreases except on reset.
- Not defined: port and register absent; behaviour otherwise identical.

Decomposition:
- Package out_buf_pkg: upstream state encodings (U_IDLE, U_ACK), downstream state encodings (D_IDLE, D_REQ, D_WAIT), default DW.
- Sub-module out_buf_fifo:
  - Holds storage array, wr/rd pointers, count, full/empty.
  - Interface: push, push_data, pop, head_data.
- Top out_buffer holds the two handshake FSMs.

Test Plan:
- Single word: CU sends 42 with the output unit model acking after 3 cycles → cu_ack 1 cycle after cu_req; ou_req carries 42; count returns 0; empty=1.
- Burst of 4 (DEPTH=4), output unit holds ack low → 4 CU acks, count=4, full=1; 5th cu_req (value 99) gets no cu_ack until the first ou_ack; then 99 is accepted.
- Ordering: CU writes 1,2,3,…,10 with a randomly delayed ou_ack → ou_data sequence exactly 1..10, each word presented once.
- Simultaneous push/pop: count=2; a CU write and an ou_ack pop land in the same cycle → count stays 2; data order preserved.
- Long cu_req: CU holds cu_req high 10 cycles after ack with value 7 → exactly one entry written (count +1 only).
- Reset mid-operation: rst_b low while ou_req=1 and count=3 → all outputs return to reset values asynchronously; after release, no stale word appears on ou_req. With OUT_BUF_HWM_EN, hwm=3 before the reset and 0 after it.

Source files
------------

// File: rtl/out_buf_pkg.sv
// Shared types and defaults for the CU-to-output-unit decoupling buffer.
package out_buf_pkg;

    localparam int unsigned DW_DEFAULT    = 16;
    localparam int unsigned DEPTH_DEFAULT = 4;

    typedef enum logic {
        U_IDLE = 1'b0,
        U_ACK  = 1'b1
    } up_state_e;

    typedef enum logic [1:0] {
        D_IDLE = 2'd0,
        D_REQ  = 2'd1,
        D_WAIT = 2'd2
    } dn_state_e;

endpackage

// File: rtl/out_buffer_if.sv
// 4-phase req/ack word channel; master drives req/data, slave drives ack.
interface out_buffer_if
    import out_buf_pkg::*;
#(
    parameter int unsigned DW = DW_DEFAULT
);

    logic          req;
    logic [DW-1:0] data;
    logic          ack;

    modport master (output req, output data, input ack);
    modport slave  (input req, input data, output ack);

endinterface

// File: rtl/out_buf_fifo.sv
// Small circular FIFO with occupancy counter; head word is read combinationally.
module out_buf_fifo
    import out_buf_pkg::*;
#(
    parameter  int unsigned DW    = DW_DEFAULT,
    parameter  int unsigned DEPTH = DEPTH_DEFAULT,
    localparam int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_b,
    input  logic          push,
    input  logic [DW-1:0] push_data,
    input  logic          pop,
    output logic [DW-1:0] head_data,
    output logic [AW:0]   count,
    output logic          full,
    output logic          empty
);

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    // Never overwrite a live entry or pop a phantom one.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally at AW bits.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    assign head_data = mem[rd_ptr];
    assign full      = (count == (AW+1)'(DEPTH));
    assign empty     = (count == '0);

endmodule

// File: rtl/out_buffer.sv
// CU-to-output-unit decoupling buffer: upstream and downstream 4-phase FSMs around a FIFO.
// Optional OUT_BUF_HWM_EN adds the hwm (high-water mark of occupancy) output.
module out_buffer
    import out_buf_pkg::*;
#(
    parameter  int unsigned DW    = DW_DEFAULT,
    parameter  int unsigned DEPTH = DEPTH_DEFAULT,
    localparam int unsigned AW    = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        rst_b,
    out_buffer_if.slave  cu,
    out_buffer_if.master ou,
    output logic [AW:0] count,
    output logic        full,
    output logic        empty
`ifdef OUT_BUF_HWM_EN
    ,
    output logic [AW:0] hwm
`endif
);

    up_state_e     u_state;
    up_state_e     u_state_n;
    logic          cu_ack_n;
    logic          push;

    dn_state_e     d_state;
    dn_state_e     d_state_n;
    logic          ou_req_n;
    logic [DW-1:0] ou_data_n;
    logic          pop;
    logic [DW-1:0] head_data;

    out_buf_fifo #(
        .DW    (DW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_b     (rst_b),
        .push      (push),
        .push_data (cu.data),
        .pop       (pop),
        .head_data (head_data),
        .count     (count),
        .full      (full),
        .empty     (empty)
    );

    // Upstream state and ack register.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            u_state <= U_IDLE;
            cu.ack  <= 1'b0;
        end else begin
            u_state <= u_state_n;
            cu.ack  <= cu_ack_n;
        end
    end

    // Write once per request; hold ack until the CU drops req.
    always_comb begin
        u_state_n = u_state;
        cu_ack_n  = cu.ack;
        push      = 1'b0;
        case (u_state)
            U_IDLE: begin
                if (cu.req && !full) begin
                    push      = 1'b1;
                    cu_ack_n  = 1'b1;
                    u_state_n = U_ACK;
                end
            end
            U_ACK: begin
                if (!cu.req) begin
                    cu_ack_n  = 1'b0;
                    u_state_n = U_IDLE;
                end
            end
            default: begin
                cu_ack_n  = 1'b0;
                u_state_n = U_IDLE;
            end
        endcase
    end

    // Downstream state, request and data registers.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            d_state <= D_IDLE;
            ou.req  <= 1'b0;
            ou.data <= '0;
        end else begin
            d_state <= d_state_n;
            ou.req  <= ou_req_n;
            ou.data <= ou_data_n;
        end
    end

    // The head entry is popped only once the output unit acks it.
    always_comb begin
        d_state_n = d_state;
        ou_req_n  = ou.req;
        ou_data_n = ou.data;
        pop       = 1'b0;
        case (d_state)
            D_IDLE: begin
                if (!empty) begin
                    ou_data_n = head_data;
                    ou_req_n  = 1'b1;
                    d_state_n = D_REQ;
                end
            end
            D_REQ: begin
                if (ou.ack) begin
                    ou_req_n  = 1'b0;
                    pop       = 1'b1;
                    d_state_n = D_WAIT;
                end
            end
            D_WAIT: begin
                if (!ou.ack) begin
                    d_state_n = D_IDLE;
                end
            end
            default: begin
                ou_req_n  = 1'b0;
                d_state_n = D_IDLE;
            end
        endcase
    end

`ifdef OUT_BUF_HWM_EN
    logic [AW:0] count_n;

    // Track the peak of the occupancy the FIFO is about to hold.
    assign count_n = count + (AW+1)'(push) - (AW+1)'(pop);

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            hwm <= '0;
        end else if (count_n > hwm) begin
            hwm <= count_n;
        end
    end
`endif

endmodule

// File: tb/tb_out_buffer.sv
// Scoreboard bench for out_buffer; a single process drives the CU side and models the output unit.
module tb_out_buffer;

    logic        clk = 1'b0;
    logic        rst_b;
    logic [2:0]  count;
    logic        full;
    logic        empty;
`ifdef OUT_BUF_HWM_EN
    logic [2:0]  hwm;
`endif

    out_buffer_if #(.DW(16)) cu_if ();
    out_buffer_if #(.DW(16)) ou_if ();

    out_buffer #(
        .DW    (16),
        .DEPTH (4)
    ) dut (
        .clk   (clk),
        .rst_b (rst_b),
        .cu    (cu_if),
        .ou    (ou_if),
        .count (count),
        .full  (full),
        .empty (empty)
`ifdef OUT_BUF_HWM_EN
        ,
        .hwm   (hwm)
`endif
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [15:0] exp_q [$];

    bit          ou_hold;
    bit          ou_rand;
    bit          ou_seen;
    int          ou_wait;
    int          ou_delay;
    int          n_pres;
    logic [15:0] ou_cur;

    // Output-unit model step: checks each offered word against the scoreboard, then acks late.
    task automatic ou_step();
        if (!rst_b) begin
            ou_if.ack = 1'b0;
            ou_seen   = 1'b0;
            ou_wait   = 0;
        end else if (ou_if.ack) begin
            if (!ou_if.req) ou_if.ack = 1'b0;
        end else if (ou_if.req) begin
            if (!ou_seen) begin
                ou_seen  = 1'b1;
                ou_wait  = 0;
                n_pres++;
                ou_delay = ou_rand ? int'($urandom_range(0, 5)) : 3;
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    ou_cur = ou_if.data;
                    $display("FAIL ou_unexpected: got word %0d, required none", ou_if.data);
                end else begin
                    ou_cur = exp_q.pop_front();
                    if (ou_if.data !== ou_cur) begin
                        n_err++;
                        $display("FAIL ou_data: got %0d, required %0d", ou_if.data, ou_cur);
                    end
                end
            end else begin
                n_cmp++;
                if (ou_if.data !== ou_cur) begin
                    n_err++;
                    $display("FAIL ou_data_stable: got %0d, required %0d", ou_if.data, ou_cur);
                end
            end
            if (!ou_hold && ou_wait >= ou_delay) begin
                ou_if.ack = 1'b1;
                ou_seen   = 1'b0;
            end else begin
                ou_wait++;
            end
        end
    endtask

    // One clock: model reacts just after the edge, stimulus/checks at the falling edge.
    task automatic cycle();
        @(posedge clk);
        #2;
        ou_step();
        @(negedge clk);
    endtask

    task automatic wait_ack_low();
        int n = 0;
        while (cu_if.ack !== 1'b0 && n < 20) begin
            cycle();
            n++;
        end
        n_cmp++;
        if (cu_if.ack !== 1'b0) begin
            n_err++;
            $display("FAIL cu_ack_release: got %b, required 0", cu_if.ack);
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while (!(count === 3'd0 && ou_if.req === 1'b0 && ou_if.ack === 1'b0) && n < 500) begin
            cycle();
            n++;
        end
        n_cmp++;
        if (count !== 3'd0 || ou_if.req !== 1'b0) begin
            n_err++;
            $display("FAIL drain_timeout: count=%0d req=%b, required 0/0", count, ou_if.req);
        end
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_left: %0d words never shown, required 0", exp_q.size());
        end
    endtask

    task automatic cu_write(input logic [15:0] d, input int extra, input bit chk_lat);
        int n = 0;
        cu_if.req  = 1'b1;
        cu_if.data = d;
        do begin
            cycle();
            n++;
        end while (cu_if.ack !== 1'b1 && n < 300);
        n_cmp++;
        if (cu_if.ack !== 1'b1) begin
            n_err++;
            $display("FAIL cu_ack_timeout: ack=%b for word %0d, required 1", cu_if.ack, d);
        end else begin
            exp_q.push_back(d);
            if (chk_lat) begin
                n_cmp++;
                if (n != 1) begin
                    n_err++;
                    $display("FAIL cu_ack_latency: got %0d cycles, required 1", n);
                end
            end
        end
        repeat (extra) cycle();
        cu_if.req = 1'b0;
        wait_ack_low();
    endtask

    task automatic check_reset_vals(input string tag);
        n_cmp++;
        if (cu_if.ack !== 1'b0 || ou_if.req !== 1'b0 || ou_if.data !== 16'd0) begin
            n_err++;
            $display("FAIL %s_hs: ack=%b req=%b data=%0d, required 0/0/0",
                     tag, cu_if.ack, ou_if.req, ou_if.data);
        end
        n_cmp++;
        if (count !== 3'd0 || empty !== 1'b1 || full !== 1'b0) begin
            n_err++;
            $display("FAIL %s_occ: count=%0d empty=%b full=%b, required 0/1/0",
                     tag, count, empty, full);
        end
`ifdef OUT_BUF_HWM_EN
        n_cmp++;
        if (hwm !== 3'd0) begin
            n_err++;
            $display("FAIL %s_hwm: got %0d, required 0", tag, hwm);
        end
`endif
    endtask

    task automatic test_reset();
        rst_b = 1'b0;
        repeat (2) cycle();
        check_reset_vals("reset");
        rst_b = 1'b1;
        cycle();
    endtask

    task automatic test_single();
        int p0 = n_pres;
        ou_hold = 1'b0;
        ou_rand = 1'b0;
        cu_write(16'd42, 0, 1'b1);
        wait_idle();
        n_cmp++;
        if (n_pres - p0 != 1) begin
            n_err++;
            $display("FAIL single_presented: got %0d, required 1", n_pres - p0);
        end
        n_cmp++;
        if (empty !== 1'b1) begin
            n_err++;
            $display("FAIL single_empty: got %b, required 1", empty);
        end
    endtask

    task automatic test_burst();
        int n = 0;
        ou_hold = 1'b1;
        for (int i = 0; i < 4; i++) cu_write(16'(10 + i), 0, 1'b1);
        n_cmp++;
        if (count !== 3'd4 || full !== 1'b1) begin
            n_err++;
            $display("FAIL burst_full: count=%0d full=%b, required 4/1", count, full);
        end
`ifdef OUT_BUF_HWM_EN
        n_cmp++;
        if (hwm !== 3'd4) begin
            n_err++;
            $display("FAIL burst_hwm: got %0d, required 4", hwm);
        end
`endif
        cu_if.req  = 1'b1;
        cu_if.data = 16'd99;
        repeat (5) cycle();
        n_cmp++;
        if (cu_if.ack !== 1'b0 || count !== 3'd4) begin
            n_err++;
            $display("FAIL burst_stall: ack=%b count=%0d, required 0/4", cu_if.ack, count);
        end
        ou_hold = 1'b0;
        while (cu_if.ack !== 1'b1 && n < 50) begin
            cycle();
            n++;
        end
        n_cmp++;
        if (cu_if.ack !== 1'b1 || count !== 3'd4) begin
            n_err++;
            $display("FAIL burst_accept: ack=%b count=%0d, required 1/4", cu_if.ack, count);
        end else begin
            exp_q.push_back(16'd99);
        end
        cu_if.req = 1'b0;
        wait_ack_low();
        wait_idle();
    endtask

    task automatic test_order();
        int p0 = n_pres;
        ou_hold = 1'b0;
        ou_rand = 1'b1;
        for (int i = 1; i <= 10; i++) cu_write(16'(i), 0, 1'b0);
        wait_idle();
        ou_rand = 1'b0;
        n_cmp++;
        if (n_pres - p0 != 10) begin
            n_err++;
            $display("FAIL order_presented: got %0d, required 10", n_pres - p0);
        end
    endtask

    task automatic test_simul();
        ou_hold = 1'b1;
        cu_write(16'd20, 0, 1'b1);
        cu_write(16'd21, 0, 1'b1);
        repeat (3) cycle();
        n_cmp++;
        if (count !== 3'd2 || ou_if.req !== 1'b1) begin
            n_err++;
            $display("FAIL simul_setup: count=%0d req=%b, required 2/1", count, ou_if.req);
        end
        ou_hold = 1'b0;
        cycle();
        // ack is now up; the next edge samples it together with the new write
        cu_if.req  = 1'b1;
        cu_if.data = 16'd22;
        cycle();
        n_cmp++;
        if (cu_if.ack !== 1'b1 || count !== 3'd2) begin
            n_err++;
            $display("FAIL simul_count: ack=%b count=%0d, required 1/2", cu_if.ack, count);
        end
        if (cu_if.ack === 1'b1) exp_q.push_back(16'd22);
        cu_if.req = 1'b0;
        wait_ack_low();
        wait_idle();
    endtask

    task automatic test_long_req();
        ou_hold = 1'b1;
        cu_write(16'd7, 10, 1'b1);
        n_cmp++;
        if (count !== 3'd1) begin
            n_err++;
            $display("FAIL long_req_count: got %0d, required 1", count);
        end
        ou_hold = 1'b0;
        wait_idle();
    endtask

    task automatic test_reset_mid();
        int reqs = 0;
        int p0;
        rst_b = 1'b0;
        cycle();
        rst_b = 1'b1;
        cycle();
        ou_hold = 1'b1;
        for (int i = 0; i < 3; i++) cu_write(16'(30 + i), 0, 1'b1);
        repeat (2) cycle();
        n_cmp++;
        if (count !== 3'd3 || ou_if.req !== 1'b1) begin
            n_err++;
            $display("FAIL mid_setup: count=%0d req=%b, required 3/1", count, ou_if.req);
        end
`ifdef OUT_BUF_HWM_EN
        n_cmp++;
        if (hwm !== 3'd3) begin
            n_err++;
            $display("FAIL mid_hwm: got %0d, required 3", hwm);
        end
`endif
        #2 rst_b = 1'b0;
        #1 check_reset_vals("mid_reset");
        exp_q.delete();
        p0 = n_pres;
        repeat (2) cycle();
        rst_b   = 1'b1;
        ou_hold = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cycle();
            if (ou_if.req === 1'b1) reqs++;
        end
        n_cmp++;
        if (reqs != 0 || count !== 3'd0 || n_pres != p0) begin
            n_err++;
            $display("FAIL mid_stale: req_cycles=%0d count=%0d shown=%0d, required 0/0/0",
                     reqs, count, n_pres - p0);
        end
    endtask

    initial begin
        rst_b      = 1'b0;
        cu_if.req  = 1'b0;
        cu_if.data = 16'd0;
        ou_if.ack  = 1'b0;
        ou_hold    = 1'b0;
        ou_rand    = 1'b0;
        ou_seen    = 1'b0;
        ou_wait    = 0;
        ou_delay   = 3;
        n_pres     = 0;
        ou_cur     = 16'd0;
        test_reset();
        test_single();
        test_burst();
        test_order();
        test_simul();
        test_long_req();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
